// File: rtl/trace_frame_host.sv
// trace_frame_host
//
// Host-side controller for the sensor-trace UART responder. One acquisition
// runs as follows:
//   1. Send a single command byte to the UART transmitter.
//   2. Receive the reply frame: 16 plaintext bytes, 16 key bytes,
//      16 ciphertext bytes, then SAMPLES sensor bytes.
//   3. Present the three 128-bit fields, a readable sample buffer and the
//      sum of all samples.
// A gap timer aborts the frame if the responder goes quiet for too long.
//
// Optional feature (compile-time macro FRAME_KEY_CHECK_EN):
//   Each received key byte is compared against KEY_EXPECT. Any mismatch
//   raises key_err, which stays set until the next accepted start. Without
//   the macro, key_err is tied to 0 and no comparator is built.
//
// Parameters:
//   SAMPLES     sensor bytes per frame
//   ADDRW       sample buffer address width (2**ADDRW >= SAMPLES)
//   TIMEOUT     maximum idle clocks allowed between received bytes
//   KEY_EXPECT  reference key (used only with FRAME_KEY_CHECK_EN)
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   start, cmd           one-cycle acquisition request and its command byte
//   tx_dv, tx_byte       strobe and byte to uart_tx
//   rx_dv, rx_byte       strobe and byte from uart_rx
//   pt, key, ct          received fields; byte i maps to bits [127-8i -: 8]
//   smp_rd_addr/_data    sample buffer read port (1-cycle registered read)
//   sample_sum           sum of the samples of the current/last frame
//   busy                 acquisition in progress
//   frame_done, timeout  one-cycle completion / abort pulses
//   key_err              key mismatch flag (sticky until next start)
module trace_frame_host #(
   parameter int           SAMPLES    = 2048,
   parameter int           ADDRW      = 11,
   parameter int           TIMEOUT    = 1000000,
   parameter logic [127:0] KEY_EXPECT = 128'h000102030405060708090a0b0c0d0ef0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [7:0]         cmd,
   output logic               tx_dv,
   output logic [7:0]         tx_byte,
   input  logic               rx_dv,
   input  logic [7:0]         rx_byte,
   output logic [127:0]       pt,
   output logic [127:0]       key,
   output logic [127:0]       ct,
   input  logic [ADDRW-1:0]   smp_rd_addr,
   output logic [7:0]         smp_rd_data,
   output logic [ADDRW+7:0]   sample_sum,
   output logic               busy,
   output logic               frame_done,
   output logic               timeout,
   output logic               key_err
);

   localparam int              TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]   TMAX     = TW'(TIMEOUT - 1);
   localparam logic [ADDRW-1:0] SMP_LAST = ADDRW'(SAMPLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND_CMD,
      S_RX_PT,
      S_RX_KEY,
      S_RX_CT,
      S_RX_SMP,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic                tx_dv_q, tx_dv_d;
   logic [7:0]          tx_byte_q, tx_byte_d;
   logic [127:0]        pt_q, pt_d;
   logic [127:0]        key_q, key_d;
   logic [127:0]        ct_q, ct_d;
   logic [ADDRW+7:0]    sum_q, sum_d;
   logic                busy_q, busy_d;
   logic                frame_done_q, frame_done_d;
   logic                timeout_q, timeout_d;
   logic [3:0]          byte_cnt_q, byte_cnt_d;
   logic [ADDRW-1:0]    smp_cnt_q, smp_cnt_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic                buf_we;
   logic [6:0]          slot_lsb;
   logic [7:0]          smp_rd_data_q;
   logic [7:0]          smp_mem [0:(1<<ADDRW)-1];

`ifdef FRAME_KEY_CHECK_EN
   logic                key_err_q, key_err_d;

   // Reference key byte idx, taken from the same big-endian byte layout
   // as the received fields.
   function automatic logic [7:0] key_ref(input logic [3:0] idx);
      logic [127:0] s;
      s = KEY_EXPECT >> {~idx, 3'b000};
      return s[7:0];
   endfunction
`endif

   // Byte slot n sits at bits [(15-n)*8 +: 8]; for a 4-bit n, 15-n == ~n.
   assign slot_lsb = {~byte_cnt_q, 3'b000};

   always_comb begin
      state_d      = state_q;
      tx_dv_d      = 1'b0;
      tx_byte_d    = tx_byte_q;
      pt_d         = pt_q;
      key_d        = key_q;
      ct_d         = ct_q;
      sum_d        = sum_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      timeout_d    = 1'b0;
      byte_cnt_d   = byte_cnt_q;
      smp_cnt_d    = smp_cnt_q;
      timer_d      = timer_q;
      buf_we       = 1'b0;
`ifdef FRAME_KEY_CHECK_EN
      key_err_d    = key_err_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            // Bytes arriving while idle are dropped.
            if (start) begin
               state_d    = S_SEND_CMD;
               tx_dv_d    = 1'b1;
               tx_byte_d  = cmd;
               busy_d     = 1'b1;
               byte_cnt_d = '0;
               smp_cnt_d  = '0;
               sum_d      = '0;
               timer_d    = '0;
`ifdef FRAME_KEY_CHECK_EN
               key_err_d  = 1'b0;
`endif
            end
         end

         // The tx strobe was raised on entry; the responder waits well
         // beyond one UART byte before replying, so tx completion is not
         // tracked.
         S_SEND_CMD: state_d = S_RX_PT;

         S_RX_PT, S_RX_KEY, S_RX_CT, S_RX_SMP: begin
            if (rx_dv) begin
               timer_d = '0;
               if (state_q == S_RX_SMP) begin
                  buf_we    = 1'b1;
                  sum_d     = sum_q + {{ADDRW{1'b0}}, rx_byte};
                  smp_cnt_d = smp_cnt_q + 1'b1;
                  if (smp_cnt_q == SMP_LAST) state_d = S_DONE;
               end else begin
                  byte_cnt_d = byte_cnt_q + 4'd1;
                  case (state_q)
                     S_RX_PT:  pt_d[slot_lsb +: 8]  = rx_byte;
                     S_RX_KEY: key_d[slot_lsb +: 8] = rx_byte;
                     default:  ct_d[slot_lsb +: 8]  = rx_byte;
                  endcase
`ifdef FRAME_KEY_CHECK_EN
                  if (state_q == S_RX_KEY && rx_byte != key_ref(byte_cnt_q))
                     key_err_d = 1'b1;
`endif
                  if (byte_cnt_q == 4'd15) begin
                     case (state_q)
                        S_RX_PT:  state_d = S_RX_KEY;
                        S_RX_KEY: state_d = S_RX_CT;
                        default:  state_d = S_RX_SMP;
                     endcase
                  end
               end
            end else if (timer_q == TMAX) begin
               // Abort; partially received data stays visible.
               timeout_d = 1'b1;
               busy_d    = 1'b0;
               state_d   = S_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         S_DONE: begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         tx_dv_q      <= 1'b0;
         tx_byte_q    <= 8'd0;
         pt_q         <= '0;
         key_q        <= '0;
         ct_q         <= '0;
         sum_q        <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         timeout_q    <= 1'b0;
         byte_cnt_q   <= '0;
         smp_cnt_q    <= '0;
         timer_q      <= '0;
`ifdef FRAME_KEY_CHECK_EN
         key_err_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         tx_dv_q      <= tx_dv_d;
         tx_byte_q    <= tx_byte_d;
         pt_q         <= pt_d;
         key_q        <= key_d;
         ct_q         <= ct_d;
         sum_q        <= sum_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         timeout_q    <= timeout_d;
         byte_cnt_q   <= byte_cnt_d;
         smp_cnt_q    <= smp_cnt_d;
         timer_q      <= timer_d;
`ifdef FRAME_KEY_CHECK_EN
         key_err_q    <= key_err_d;
`endif
      end
   end

   // Sample buffer: one write port, one registered read port.
   // A same-address read and write in one cycle returns the old contents.
   always_ff @(posedge clk) begin
      if (buf_we && !rst) smp_mem[smp_cnt_q] <= rx_byte;
      smp_rd_data_q <= smp_mem[smp_rd_addr];
   end

   assign tx_dv       = tx_dv_q;
   assign tx_byte     = tx_byte_q;
   assign pt          = pt_q;
   assign key         = key_q;
   assign ct          = ct_q;
   assign sample_sum  = sum_q;
   assign busy        = busy_q;
   assign frame_done  = frame_done_q;
   assign timeout     = timeout_q;
   assign smp_rd_data = smp_rd_data_q;
`ifdef FRAME_KEY_CHECK_EN
   assign key_err     = key_err_q;
`else
   assign key_err     = 1'b0;
`endif

endmodule

// File: tb/tb_trace_frame_host.sv
// Self-checking bench for trace_frame_host. Expected command bytes and frame
// results are queued when stimulus is driven and popped when the DUT emits
// tx_dv or frame_done.
module tb_trace_frame_host;

   localparam int           SAMPLES    = 2048;
   localparam int           ADDRW      = 11;
   localparam int           TIMEOUT    = 200;
   localparam logic [127:0] KEY_EXPECT = 128'h000102030405060708090a0b0c0d0ef0;
`ifdef FRAME_KEY_CHECK_EN
   localparam bit KERR_ON = 1'b1;
`else
   localparam bit KERR_ON = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst, start, rx_dv;
   logic [7:0]         cmd, rx_byte;
   logic               tx_dv;
   logic [7:0]         tx_byte;
   logic [127:0]       pt, key, ct;
   logic [ADDRW-1:0]   smp_rd_addr;
   logic [7:0]         smp_rd_data;
   logic [ADDRW+7:0]   sample_sum;
   logic               busy, frame_done, timeout, key_err;

   trace_frame_host #(
      .SAMPLES(SAMPLES), .ADDRW(ADDRW), .TIMEOUT(TIMEOUT), .KEY_EXPECT(KEY_EXPECT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .cmd(cmd),
      .tx_dv(tx_dv), .tx_byte(tx_byte), .rx_dv(rx_dv), .rx_byte(rx_byte),
      .pt(pt), .key(key), .ct(ct),
      .smp_rd_addr(smp_rd_addr), .smp_rd_data(smp_rd_data),
      .sample_sum(sample_sum), .busy(busy), .frame_done(frame_done),
      .timeout(timeout), .key_err(key_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0]     pt;
      logic [127:0]     key;
      logic [127:0]     ct;
      logic [ADDRW+7:0] sum;
      logic             kerr;
   } frame_t;

   frame_t     frame_q[$];
   logic [7:0] tx_q[$];
   int         checks = 0;
   int         errors = 0;
   int         tx_cnt = 0, done_cnt = 0, to_cnt = 0;
   logic [7:0] fb [48];
   logic [7:0] exp_smp [SAMPLES];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (tx_dv === 1'b1) begin
         tx_cnt++;
         if (tx_q.size() == 0) chk("tx_unexpected", 1, 0);
         else                  chk("tx_byte", tx_byte, tx_q.pop_front());
      end
      if (frame_done === 1'b1) done_cnt++;
      if (timeout === 1'b1)    to_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] smp_of(input int mode, input int i);
      case (mode)
         0:       return 8'h01;
         1:       return 8'hFF;
         default: return 8'((i * 37 + 11) & 255);
      endcase
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_dv = 1'b1;
      rx_byte = b;
      tick();
      rx_dv = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic do_start(input logic [7:0] c);
      start = 1'b1;
      cmd = c;
      tx_q.push_back(c);
      tick();
      start = 1'b0;
      cmd = ~c;
      chk("busy_after_start", busy, 1);
      chk("tx_dv_after_start", tx_dv, 1);
      chk("key_err_cleared", key_err, 0);
      tick();
   endtask

   task automatic run_full(input logic [7:0] c, input int mode, input int gap,
                           input bit poke_start, input bit key_probe);
      frame_t e;
      int     d0;
      e.pt = '0; e.key = '0; e.ct = '0; e.sum = '0;
      for (int i = 0; i < 16; i++) begin
         e.pt  = {e.pt[119:0],  fb[i]};
         e.key = {e.key[119:0], fb[16+i]};
         e.ct  = {e.ct[119:0],  fb[32+i]};
      end
      for (int i = 0; i < SAMPLES; i++) begin
         exp_smp[i] = smp_of(mode, i);
         e.sum = e.sum + (ADDRW+8)'(exp_smp[i]);
      end
      e.kerr = KERR_ON && (e.key != KEY_EXPECT);
      frame_q.push_back(e);
      d0 = done_cnt;
      do_start(c);
      for (int i = 0; i < 48; i++) begin
         send_byte(fb[i], gap);
         if (key_probe && i == 20) chk("key_err_before_b5", key_err, 0);
         if (key_probe && i == 21) chk("key_err_after_b5", key_err, KERR_ON);
         if (poke_start && i == 35) begin
            start = 1'b1;
            cmd = 8'h33;
            tick();
            start = 1'b0;
            chk("busy_during_poke", busy, 1);
         end
      end
      for (int i = 0; i < SAMPLES; i++)
         send_byte(exp_smp[i], (i == SAMPLES - 1) ? 0 : gap);
      chk("sum_at_m1", sample_sum, e.sum);
      chk("done_low_m1", frame_done, 0);
      chk("busy_high_m1", busy, 1);
      tick();
      chk("done_at_m2", frame_done, 1);
      chk("busy_low_m2", busy, 0);
      if (frame_q.size() == 0) chk("frame_unexpected", 1, 0);
      else begin
         e = frame_q.pop_front();
         chk("pt", pt, e.pt);
         chk("key", key, e.key);
         chk("ct", ct, e.ct);
         chk("sum", sample_sum, e.sum);
         chk("key_err", key_err, e.kerr);
      end
      tick();
      chk("done_one_pulse", frame_done, 0);
      chk("done_count", done_cnt - d0, 1);
      smp_rd_addr = ADDRW'(SAMPLES - 1);
      tick();
      chk("rd_last", smp_rd_data, exp_smp[SAMPLES-1]);
      smp_rd_addr = ADDRW'(100);
      tick();
      chk("rd_100", smp_rd_data, exp_smp[100]);
   endtask

   initial begin
      logic [127:0] kx, ept, sv_pt, sv_key, sv_ct;
      logic [ADDRW+7:0] sv_sum;
      int k, d0, t0;
      rst = 1'b1; start = 1'b0; cmd = 8'h00; rx_dv = 1'b0; rx_byte = 8'h00;
      smp_rd_addr = '0;
      repeat (3) tick();
      chk("rst_tx_dv", tx_dv, 0);
      chk("rst_tx_byte", tx_byte, 0);
      chk("rst_pt", pt, 0);
      chk("rst_key", key, 0);
      chk("rst_ct", ct, 0);
      chk("rst_sum", sample_sum, 0);
      chk("rst_flags", {busy, frame_done, timeout, key_err}, 0);
      rst = 1'b0;
      tick();

      // Normal frame
      for (int i = 0; i < 48; i++) fb[i] = 8'(i);
      run_full(8'hFA, 0, 1, 0, 0);
      chk("normal_pt_const", pt, 128'h000102030405060708090a0b0c0d0e0f);
      chk("normal_ct_last", ct[7:0], 8'h2F);
      chk("normal_sum_const", sample_sum, 2048);
      chk("normal_tx_count", tx_cnt, 1);

      // Timeout after 20 bytes
      d0 = done_cnt; t0 = to_cnt;
      do_start(8'h05);
      for (int i = 0; i < 20; i++) send_byte(8'(8'h80 + i), (i == 19) ? 0 : 1);
      k = 0;
      while (timeout !== 1'b1 && k < TIMEOUT + 10) begin
         tick();
         k++;
      end
      chk("timeout_seen", timeout, 1);
      chk("timeout_latency_ok", (k >= TIMEOUT - 1 && k <= TIMEOUT + 1), 1);
      chk("timeout_busy", busy, 0);
      ept = '0;
      for (int i = 0; i < 16; i++) ept = {ept[119:0], 8'(8'h80 + i)};
      chk("timeout_partial_pt", pt, ept);
      chk("timeout_partial_key", key[127:96], 32'h90919293);
      tick();
      chk("timeout_one_pulse", timeout, 0);
      chk("timeout_count", to_cnt - t0, 1);
      chk("timeout_no_done", done_cnt - d0, 0);

      // Start ignored during RX_CT, then bytes ignored while idle
      for (int i = 0; i < 48; i++) fb[i] = 8'(255 - i);
      run_full(8'h11, 2, 0, 1, 0);
      sv_pt = pt; sv_key = key; sv_ct = ct; sv_sum = sample_sum;
      for (int i = 0; i < 5; i++) send_byte(8'(8'h5A + i), 1);
      chk("idle_pt", pt, sv_pt);
      chk("idle_key", key, sv_key);
      chk("idle_ct", ct, sv_ct);
      chk("idle_sum", sample_sum, sv_sum);
      chk("idle_busy", busy, 0);
      chk("tx_count_3", tx_cnt, 3);

      // Reset in RX_SMP at smp_cnt=100
      t0 = to_cnt;
      do_start(8'h1F);
      for (int i = 0; i < 48; i++) send_byte(fb[i], 0);
      for (int i = 0; i < 100; i++) send_byte(8'h07, 0);
      rst = 1'b1;
      tick();
      chk("mid_rst_tx", {tx_dv, tx_byte}, 0);
      chk("mid_rst_pt", pt, 0);
      chk("mid_rst_key", key, 0);
      chk("mid_rst_ct", ct, 0);
      chk("mid_rst_sum", sample_sum, 0);
      chk("mid_rst_flags", {busy, frame_done, timeout, key_err}, 0);
      rst = 1'b0;
      tick();
      chk("mid_rst_no_timeout", to_cnt - t0, 0);
      for (int i = 0; i < 48; i++) fb[i] = 8'(i * 3);
      run_full(8'hFA, 2, 1, 0, 0);

      // Key with byte 5 corrupted
      kx = KEY_EXPECT;
      for (int i = 0; i < 16; i++) begin
         fb[i]    = 8'(8'h40 + i);
         fb[16+i] = kx[127 - 8*i -: 8];
         fb[32+i] = 8'(8'hC0 + i);
      end
      fb[21] = 8'hFF;
      run_full(8'hFA, 0, 0, 0, 1);

      // Back-to-back stream, all samples 0xFF
      for (int i = 0; i < 48; i++) fb[i] = 8'(i);
      run_full(8'hFA, 1, 0, 0, 0);
      chk("b2b_sum_const", sample_sum, 19'd522240);
      chk("tx_queue_empty", tx_q.size(), 0);
      chk("frame_queue_empty", frame_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
